// File: rtl/rgen_csr_pkg.sv
// Shared types and address helpers for the APB CSR bank and its access controller.
package rgen_csr_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } apb_state_e;

   typedef enum logic {
      ACC_RW  = 1'b0,
      ACC_W1C = 1'b1
   } rgen_access_type_e;

   // Wide enough for the largest supported wait-state count (7).
   localparam int WAIT_CNT_WIDTH = 3;

   function automatic int addr_lsb(input int data_width);
      return $clog2(data_width / 8);
   endfunction

   function automatic int index_width(input int local_aw, input int data_width);
      return local_aw - addr_lsb(data_width);
   endfunction

endpackage

// File: rtl/rgen_apb_access_ctrl.sv
// APB slave handshake: IDLE/ACCESS state machine, wait-state counter and word-index decode.
module rgen_apb_access_ctrl
   import rgen_csr_pkg::*;
#(
   parameter int DATA_WIDTH          = 32,
   parameter int HOST_ADDRESS_WIDTH  = 16,
   parameter int LOCAL_ADDRESS_WIDTH = 8,
   parameter int WAIT_STATES         = 0,
   parameter int INDEX_WIDTH         = index_width(LOCAL_ADDRESS_WIDTH, DATA_WIDTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [HOST_ADDRESS_WIDTH-1:0] paddr,
   input  logic                          psel,
   input  logic                          penable,
   input  logic                          pwrite,
   output logic                          pready,
   output logic                          access_valid,
   output logic                          access_write,
   output logic [INDEX_WIDTH-1:0]        word_index
);

   localparam int                        LSB       = addr_lsb(DATA_WIDTH);
   localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LAST = WAIT_CNT_WIDTH'(WAIT_STATES);

   apb_state_e                state, state_next;
   logic [WAIT_CNT_WIDTH-1:0] wait_cnt, wait_cnt_next;
   logic                      ready_raw;
   logic                      unused_addr;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   // NOTE: every output of this block is defaulted first, so no path through
   // the case statement can leave a value held and infer a latch.
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      ready_raw     = 1'b0;
      case (state)
         ST_IDLE: begin
            wait_cnt_next = '0;
            if (psel && !penable) state_next = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (!psel) begin
               state_next    = ST_IDLE;
               wait_cnt_next = '0;
            end else if (penable) begin
               if (wait_cnt == WAIT_LAST) begin
                  ready_raw     = 1'b1;
                  state_next    = ST_IDLE;
                  wait_cnt_next = '0;
               end else begin
                  wait_cnt_next = wait_cnt + 1'b1;
               end
            end
         end
         default: begin
            state_next    = ST_IDLE;
            wait_cnt_next = '0;
         end
      endcase
   end

   // Reset overrides an in-flight completion so no write can commit under reset.
   assign pready       = ready_raw & ~rst;
   assign access_valid = pready;
   assign access_write = pwrite;
   assign word_index   = paddr[LOCAL_ADDRESS_WIDTH-1:LSB];

   // Byte-offset and upper host bits are deliberately ignored.
   assign unused_addr = ^paddr;

endmodule

// File: rtl/rgen_apb_csr_bank.sv
// APB CSR bank: NUM_RW read/write registers plus W1C IRQ_STATUS and IRQ_ENABLE.
// Optional build macro RGEN_APB_CSR_SLVERR_EN enables PSLVERR on unmapped or empty-strobe accesses.
module rgen_apb_csr_bank
   import rgen_csr_pkg::*;
#(
   parameter int                            DATA_WIDTH          = 32,
   parameter int                            HOST_ADDRESS_WIDTH  = 16,
   parameter int                            LOCAL_ADDRESS_WIDTH = 8,
   parameter int                            NUM_RW              = 4,
   parameter logic [NUM_RW*DATA_WIDTH-1:0]  INITIAL_VALUE       = '0,
   parameter int                            WAIT_STATES         = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [HOST_ADDRESS_WIDTH-1:0]  i_paddr,
   input  logic [2:0]                     i_pprot,
   input  logic                           i_psel,
   input  logic                           i_penable,
   input  logic                           i_pwrite,
   input  logic [DATA_WIDTH-1:0]          i_pwdata,
   input  logic [DATA_WIDTH/8-1:0]        i_pstrb,
   output logic                           o_pready,
   output logic [DATA_WIDTH-1:0]          o_prdata,
   output logic                           o_pslverr,
   output logic [NUM_RW*DATA_WIDTH-1:0]   o_rw_value,
   input  logic [DATA_WIDTH-1:0]          i_irq_set,
   output logic                           o_irq
);

   localparam int               STRB_W     = DATA_WIDTH / 8;
   localparam int               IDX_W      = index_width(LOCAL_ADDRESS_WIDTH, DATA_WIDTH);
   localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(NUM_RW);
   localparam logic [IDX_W-1:0] IDX_ENABLE = IDX_W'(NUM_RW + 1);

   logic                    pready;
   logic                    access_valid;
   logic                    access_write;
   logic [IDX_W-1:0]        word_index;
   logic [DATA_WIDTH-1:0]   byte_mask;
   logic [DATA_WIDTH-1:0]   wr_masked;
   logic [DATA_WIDTH-1:0]   status_clear;
   logic [DATA_WIDTH-1:0]   rd_value;
   logic                    mapped;
   logic                    wr_commit;
   rgen_access_type_e       acc_type;
   logic                    unused_pprot;

   logic [DATA_WIDTH-1:0]   rw_q [NUM_RW];
   logic [DATA_WIDTH-1:0]   irq_status_q;
   logic [DATA_WIDTH-1:0]   irq_enable_q;

   rgen_apb_access_ctrl #(
      .DATA_WIDTH          (DATA_WIDTH),
      .HOST_ADDRESS_WIDTH  (HOST_ADDRESS_WIDTH),
      .LOCAL_ADDRESS_WIDTH (LOCAL_ADDRESS_WIDTH),
      .WAIT_STATES         (WAIT_STATES),
      .INDEX_WIDTH         (IDX_W)
   ) u_access_ctrl (
      .clk          (clk),
      .rst          (rst),
      .paddr        (i_paddr),
      .psel         (i_psel),
      .penable      (i_penable),
      .pwrite       (i_pwrite),
      .pready       (pready),
      .access_valid (access_valid),
      .access_write (access_write),
      .word_index   (word_index)
   );

   always_comb begin
      byte_mask = '0;
      for (int b = 0; b < STRB_W; b++) begin
         byte_mask[b*8 +: 8] = {8{i_pstrb[b]}};
      end
   end

   assign wr_masked    = i_pwdata & byte_mask;
   assign wr_commit    = access_valid & access_write;
   assign acc_type     = (word_index == IDX_STATUS) ? ACC_W1C : ACC_RW;
   assign status_clear = (wr_commit && acc_type == ACC_W1C) ? wr_masked : '0;

   // NOTE: the register array is reset explicitly because each entry has its
   // own INITIAL_VALUE; this forces flops rather than a RAM macro, which is intended.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_RW; i++) begin
            rw_q[i] <= INITIAL_VALUE[i*DATA_WIDTH +: DATA_WIDTH];
         end
         irq_enable_q <= '0;
         irq_status_q <= '0;
      end else begin
         for (int i = 0; i < NUM_RW; i++) begin
            if (wr_commit && acc_type == ACC_RW && word_index == IDX_W'(i)) begin
               rw_q[i] <= (rw_q[i] & ~byte_mask) | wr_masked;
            end
         end
         if (wr_commit && word_index == IDX_ENABLE) begin
            irq_enable_q <= (irq_enable_q & ~byte_mask) | wr_masked;
         end
         // Event pulses are OR-ed in after the clear, so a same-cycle set wins.
         irq_status_q <= (irq_status_q & ~status_clear) | i_irq_set;
      end
   end

   always_comb begin
      rd_value = '0;
      mapped   = 1'b0;
      for (int i = 0; i < NUM_RW; i++) begin
         if (word_index == IDX_W'(i)) begin
            rd_value = rw_q[i];
            mapped   = 1'b1;
         end
      end
      if (word_index == IDX_STATUS) begin
         rd_value = irq_status_q;
         mapped   = 1'b1;
      end
      if (word_index == IDX_ENABLE) begin
         rd_value = irq_enable_q;
         mapped   = 1'b1;
      end
   end

   always_comb begin
      o_rw_value = '0;
      for (int i = 0; i < NUM_RW; i++) begin
         o_rw_value[i*DATA_WIDTH +: DATA_WIDTH] = rw_q[i];
      end
   end

   assign o_pready = pready;
   assign o_prdata = (access_valid && !access_write) ? rd_value : '0;
   assign o_irq    = ~rst & (|(irq_status_q & irq_enable_q));

`ifdef RGEN_APB_CSR_SLVERR_EN
   assign o_pslverr = access_valid & (~mapped | (access_write & (i_pstrb == '0)));
`else
   logic unused_mapped;
   assign o_pslverr     = 1'b0;
   assign unused_mapped = mapped;
`endif

   assign unused_pprot = ^i_pprot;

endmodule

// File: tb/tb_rgen_apb_csr_bank.sv
// Randomized self-checking bench for rgen_apb_csr_bank against an array-based register model.
module tb_rgen_apb_csr_bank;

   localparam int DW  = 32;
   localparam int HAW = 16;
   localparam int LAW = 8;
   localparam int NRW = 4;
   localparam int WS  = 3;
   localparam logic [NRW*DW-1:0] INIT = {32'h0F0F_00FF, 32'h0000_0000, 32'h0000_0000, 32'hA5A5_0001};
   localparam int IDX_STATUS = NRW;
   localparam int IDX_ENABLE = NRW + 1;
`ifdef RGEN_APB_CSR_SLVERR_EN
   localparam bit SLVERR = 1'b1;
`else
   localparam bit SLVERR = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [HAW-1:0]    paddr;
   logic [2:0]        pprot;
   logic              psel, penable, pwrite;
   logic [DW-1:0]     pwdata;
   logic [DW/8-1:0]   pstrb;
   logic              pready;
   logic [DW-1:0]     prdata;
   logic              pslverr;
   logic [NRW*DW-1:0] rw_value;
   logic [DW-1:0]     irq_set;
   logic              irq;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] m_rw [NRW];
   logic [DW-1:0] m_status;
   logic [DW-1:0] m_enable;

   rgen_apb_csr_bank #(
      .DATA_WIDTH          (DW),
      .HOST_ADDRESS_WIDTH  (HAW),
      .LOCAL_ADDRESS_WIDTH (LAW),
      .NUM_RW              (NRW),
      .INITIAL_VALUE       (INIT),
      .WAIT_STATES         (WS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_paddr    (paddr),
      .i_pprot    (pprot),
      .i_psel     (psel),
      .i_penable  (penable),
      .i_pwrite   (pwrite),
      .i_pwdata   (pwdata),
      .i_pstrb    (pstrb),
      .o_pready   (pready),
      .o_prdata   (prdata),
      .o_pslverr  (pslverr),
      .o_rw_value (rw_value),
      .i_irq_set  (irq_set),
      .o_irq      (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [DW-1:0] strb_mask(input logic [DW/8-1:0] s);
      logic [DW-1:0] m;
      m = '0;
      for (int b = 0; b < DW/8; b++) m[8*b +: 8] = s[b] ? 8'hFF : 8'h00;
      return m;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NRW; i++) m_rw[i] = INIT[i*DW +: DW];
      m_status = '0;
      m_enable = '0;
   endtask

   function automatic logic [DW-1:0] model_read(input int idx);
      if (idx < NRW)        return m_rw[idx];
      if (idx == IDX_STATUS) return m_status;
      if (idx == IDX_ENABLE) return m_enable;
      return '0;
   endfunction

   task automatic model_write(input int idx, input logic [DW-1:0] d, input logic [DW/8-1:0] s);
      logic [DW-1:0] m;
      m = strb_mask(s);
      if (idx < NRW)              m_rw[idx] = (m_rw[idx] & ~m) | (d & m);
      else if (idx == IDX_STATUS) m_status  = m_status & ~(d & m);
      else if (idx == IDX_ENABLE) m_enable  = (m_enable & ~m) | (d & m);
   endtask

   function automatic bit expect_err(input int idx, input bit wr, input logic [DW/8-1:0] s);
      return SLVERR && ((idx > IDX_ENABLE) || (wr && s == '0));
   endfunction

   // ---------------- bus helpers ----------------
   // Called at posedge+1; returns at posedge+1 of the cycle following pready.
   task automatic apb_xfer(input int idx, input bit wr, input logic [DW-1:0] wdata,
                           input logic [DW/8-1:0] s, output logic [DW-1:0] rdata,
                           output bit err, output int cycles);
      logic [HAW-1:0] a;
      bit done;
      a = HAW'($urandom);
      a[LAW-1:2] = 6'(idx);
      paddr = a; pwrite = wr; pwdata = wdata; pstrb = s; pprot = 3'($urandom);
      psel = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      cycles = 0; rdata = '0; err = 1'b0; done = 1'b0;
      while (!done) begin
         @(negedge clk);
         cycles++;
         if (pready) begin
            rdata = prdata; err = pslverr; done = 1'b1;
            if (wr) model_write(idx, wdata, s);
         end else if (cycles >= 40) begin
            checks++; errors++;
            $display("FAIL pready_timeout: idx=%0d no pready after %0d cycles, required within %0d", idx, cycles, WS + 1);
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic apb_idle();
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_write(input int idx, input logic [DW-1:0] d, input logic [DW/8-1:0] s, output bit err);
      logic [DW-1:0] rd;
      int cy;
      apb_xfer(idx, 1'b1, d, s, rd, err, cy);
      apb_idle();
   endtask

   task automatic do_read(input int idx, output logic [DW-1:0] d, output bit err);
      int cy;
      apb_xfer(idx, 1'b0, '0, '0, d, err, cy);
      apb_idle();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [DW-1:0] d;
      bit e;
      rst = 1'b1; irq_set = '1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (pready !== 1'b0) begin errors++; $display("FAIL reset_pready: got %b want 0", pready); end
      checks++; if (prdata !== '0) begin errors++; $display("FAIL reset_prdata: got %h want 0", prdata); end
      checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr: got %b want 0", pslverr); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
      checks++; if (rw_value !== INIT) begin errors++; $display("FAIL reset_rw_value: got %h want %h", rw_value, INIT); end
      @(posedge clk); #1;
      rst = 1'b0; irq_set = '0;
      model_reset();
      @(posedge clk); #1;
      do_read(IDX_STATUS, d, e);
      checks++; if (d !== '0) begin errors++; $display("FAIL reset_irq_set_ignored: status got %h want 0", d); end
   endtask

   task automatic test_read_init();
      logic [DW-1:0] d;
      bit e;
      do_read(0, d, e);
      checks++; if (d !== 32'hA5A5_0001) begin errors++; $display("FAIL init_read0: got %h want a5a50001", d); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL init_read0_slverr: got %b want 0", e); end
      for (int i = 1; i < NRW; i++) begin
         do_read(i, d, e);
         checks++; if (d !== model_read(i)) begin errors++; $display("FAIL init_read%0d: got %h want %h", i, d, model_read(i)); end
      end
   endtask

   task automatic test_partial_write();
      logic [DW-1:0] d;
      bit e;
      do_write(1, 32'h1234_5678, 4'b0011, e);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL partial_wr_slverr: got %b want 0", e); end
      do_read(1, d, e);
      checks++; if (d !== 32'h0000_5678) begin errors++; $display("FAIL partial_wr_read: got %h want 00005678", d); end
      checks++; if (rw_value[DW +: DW] !== 32'h0000_5678) begin errors++; $display("FAIL partial_wr_rw_value: got %h want 00005678", rw_value[DW +: DW]); end
   endtask

   task automatic test_wait_states();
      logic [DW-1:0] d;
      bit e;
      int cy;
      apb_xfer(0, 1'b0, '0, '0, d, e, cy);
      apb_idle();
      checks++; if (cy != WS + 1) begin errors++; $display("FAIL wait_latency: pready after %0d cycles want %0d", cy, WS + 1); end
      @(negedge clk);
      checks++; if (pready !== 1'b0) begin errors++; $display("FAIL wait_pready_single: got %b want 0 after transfer", pready); end
      @(posedge clk); #1;
   endtask

   task automatic test_irq();
      logic [DW-1:0] d, set_v;
      bit e;
      int cy;
      do_write(IDX_ENABLE, 32'h4, 4'hF, e);
      @(negedge clk);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b want 0", irq); end
      @(posedge clk); #1;
      irq_set = 32'h4;
      @(posedge clk); #1;
      irq_set = '0; m_status |= 32'h4;
      @(negedge clk);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b want 1", irq); end
      @(posedge clk); #1;
      // W1C while the same bit is being set: set must win.
      irq_set = 32'h4;
      apb_xfer(IDX_STATUS, 1'b1, 32'h4, 4'hF, d, e, cy);
      irq_set = '0; m_status |= 32'h4;
      apb_idle();
      do_read(IDX_STATUS, d, e);
      checks++; if (d !== 32'h4) begin errors++; $display("FAIL irq_set_wins: status got %h want 00000004", d); end
      do_write(IDX_STATUS, 32'h4, 4'hF, e);
      do_read(IDX_STATUS, d, e);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL irq_w1c_clear: status got %h want 0", d); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_deassert: got %b want 0", irq); end
      for (int k = 0; k < 8; k++) begin
         set_v = $urandom;
         irq_set = set_v;
         @(posedge clk); #1;
         irq_set = '0; m_status |= set_v;
         do_write(IDX_ENABLE, $urandom, 4'($urandom), e);
         do_write(IDX_STATUS, $urandom, 4'($urandom), e);
         do_read(IDX_STATUS, d, e);
         checks++; if (d !== m_status) begin errors++; $display("FAIL irq_rand_status[%0d]: got %h want %h", k, d, m_status); end
         checks++; if (irq !== (|(m_status & m_enable))) begin errors++; $display("FAIL irq_rand_irq[%0d]: got %b want %b", k, irq, |(m_status & m_enable)); end
      end
   endtask

   task automatic test_unmapped();
      logic [DW-1:0] d;
      bit e;
      do_read(NRW + 5, d, e);
      checks++; if (d !== '0) begin errors++; $display("FAIL unmapped_rdata: got %h want 0", d); end
      checks++; if (e !== SLVERR) begin errors++; $display("FAIL unmapped_rd_slverr: got %b want %b", e, SLVERR); end
      do_write(63, $urandom, 4'hF, e);
      checks++; if (e !== SLVERR) begin errors++; $display("FAIL unmapped_wr_slverr: got %b want %b", e, SLVERR); end
      do_write(2, 32'hFFFF_FFFF, 4'h0, e);
      checks++; if (e !== SLVERR) begin errors++; $display("FAIL zero_strb_slverr: got %b want %b", e, SLVERR); end
      for (int i = 0; i < NRW + 2; i++) begin
         do_read(i, d, e);
         checks++; if (d !== model_read(i)) begin errors++; $display("FAIL unmapped_side_effect[%0d]: got %h want %h", i, d, model_read(i)); end
      end
   endtask

   task automatic test_abort();
      logic [DW-1:0] d, old;
      bit e;
      int cy;
      old = m_rw[0];
      paddr = HAW'($urandom); paddr[LAW-1:2] = 6'd0;
      pwrite = 1'b1; pwdata = ~old; pstrb = 4'hF;
      psel = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++; if (pready !== 1'b0) begin errors++; $display("FAIL abort_no_pready[%0d]: got %b want 0", c, pready); end
         @(posedge clk); #1;
      end
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      checks++; if (pready !== 1'b0) begin errors++; $display("FAIL abort_drop_pready: got %b want 0", pready); end
      @(posedge clk); #1;
      apb_xfer(0, 1'b0, '0, '0, d, e, cy);
      apb_idle();
      checks++; if (d !== old) begin errors++; $display("FAIL abort_reg0: got %h want %h", d, old); end
      checks++; if (cy != WS + 1) begin errors++; $display("FAIL abort_counter_cleared: latency %0d want %0d", cy, WS + 1); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] d, d1, d2;
      bit e;
      int cy;
      logic [DW/8-1:0] s2;
      d1 = $urandom; d2 = $urandom; s2 = 4'($urandom);
      apb_xfer(2, 1'b1, d1, 4'hF, d, e, cy);
      apb_xfer(2, 1'b0, '0, '0, d, e, cy);
      checks++; if (d !== model_read(2)) begin errors++; $display("FAIL b2b_read2: got %h want %h", d, model_read(2)); end
      checks++; if (cy != WS + 1) begin errors++; $display("FAIL b2b_latency2: %0d want %0d", cy, WS + 1); end
      apb_xfer(3, 1'b1, d2, s2, d, e, cy);
      apb_xfer(3, 1'b0, '0, '0, d, e, cy);
      apb_idle();
      checks++; if (d !== model_read(3)) begin errors++; $display("FAIL b2b_read3: got %h want %h", d, model_read(3)); end
      checks++; if (cy != WS + 1) begin errors++; $display("FAIL b2b_latency3: %0d want %0d", cy, WS + 1); end
   endtask

   task automatic test_random_rw();
      logic [DW-1:0] d, exp_d, wd;
      logic [DW/8-1:0] s;
      bit e, wr;
      int idx, cy;
      for (int k = 0; k < 24; k++) begin
         idx = $urandom_range(0, NRW + 2);
         wr = 1'($urandom);
         wd = $urandom;
         s = 4'($urandom);
         exp_d = wr ? '0 : model_read(idx);
         apb_xfer(idx, wr, wd, s, d, e, cy);
         apb_idle();
         checks++; if (d !== exp_d) begin errors++; $display("FAIL rand_rdata[%0d]: idx=%0d wr=%0d got %h want %h", k, idx, wr, d, exp_d); end
         checks++; if (e !== expect_err(idx, wr, s)) begin errors++; $display("FAIL rand_slverr[%0d]: idx=%0d got %b want %b", k, idx, e, expect_err(idx, wr, s)); end
      end
      for (int i = 0; i < NRW; i++) begin
         checks++; if (rw_value[i*DW +: DW] !== m_rw[i]) begin errors++; $display("FAIL rand_rw_value[%0d]: got %h want %h", i, rw_value[i*DW +: DW], m_rw[i]); end
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] d;
      bit e;
      paddr = HAW'($urandom); paddr[LAW-1:2] = 6'd2;
      pwrite = 1'b1; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
      psel = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      repeat (WS) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (pready !== 1'b0) begin errors++; $display("FAIL rst_mid_pready: got %b want 0", pready); end
      checks++; if (prdata !== '0) begin errors++; $display("FAIL rst_mid_prdata: got %h want 0", prdata); end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      checks++; if (rw_value !== INIT) begin errors++; $display("FAIL rst_mid_rw_value: got %h want %h", rw_value, INIT); end
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      do_read(2, d, e);
      checks++; if (d !== model_read(2)) begin errors++; $display("FAIL rst_mid_reg2: got %h want %h", d, model_read(2)); end
   endtask

   initial begin
      test_reset();
      test_read_init();
      test_partial_write();
      test_wait_states();
      test_irq();
      test_unmapped();
      test_abort();
      test_back_to_back();
      test_random_rw();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rgen_apb_csr_bank.md
RGEN_APB_CSR_BANK -- requirements
Module: rgen_apb_csr_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, APB data width (32 or 64).
REQ-002 SHALL have parameter HOST_ADDRESS_WIDTH, default 16, paddr width.
REQ-003 SHALL have parameter LOCAL_ADDRESS_WIDTH, default 8, decoded low address bits.
REQ-004 SHALL have parameter NUM_RW, default 4, count of RW registers (1..16).
REQ-005 SHALL have parameter INITIAL_VALUE, default all-zero, NUM_RW*DATA_WIDTH reset values, register i at slice i.
REQ-006 SHALL have parameter WAIT_STATES, default 0, extra access-phase cycles before pready (0..7).
REQ-007 SHALL have ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-008 SHALL have ports: i_paddr in HOST_ADDRESS_WIDTH; i_pprot in 3 (ignored); i_psel, i_penable, i_pwrite in 1; i_pwdata in DATA_WIDTH; i_pstrb in DATA_WIDTH/8.
REQ-009 SHALL have ports: o_pready out 1; o_prdata out DATA_WIDTH; o_pslverr out 1.
REQ-010 SHALL have ports: o_rw_value out NUM_RW*DATA_WIDTH, RW register contents; i_irq_set in DATA_WIDTH, per-bit event pulses; o_irq out 1, interrupt request.

Function
REQ-011 SHALL map word index = paddr[LOCAL_ADDRESS_WIDTH-1:log2(DATA_WIDTH/8)]: 0..NUM_RW-1 RW, NUM_RW IRQ_STATUS, NUM_RW+1 IRQ_ENABLE, others unmapped; upper paddr bits ignored.
REQ-012 SHALL run FSM IDLE -> ACCESS on psel&!penable; ACCESS counts wait cycles while psel&penable; ACCESS -> IDLE on pready cycle or psel deassert.
REQ-013 SHALL assert o_pready for exactly one cycle when in ACCESS, psel&penable, and wait counter == WAIT_STATES; otherwise 0.
REQ-014 SHALL commit writes only on the pready cycle; byte lanes with pstrb=0 unchanged.
REQ-015 SHALL drive o_prdata with the addressed value on the pready cycle of a read, zero otherwise; unmapped reads return zero.
REQ-016 SHALL clear IRQ_STATUS bits where pwdata & byte-mask = 1 (W1C); writes of 0 no effect.
REQ-017 SHALL set IRQ_STATUS bit n on any cycle i_irq_set[n]=1; set wins over simultaneous W1C clear.
REQ-018 SHALL drive o_irq combinationally as |(IRQ_STATUS & IRQ_ENABLE).
REQ-019 SHALL treat psel drop during ACCESS as abort: no write, counter cleared, no pready.
REQ-020 SHALL accept back-to-back transfers: setup phase the cycle after pready.

Reset
REQ-021 SHALL on rst=1 at clk edge: FSM IDLE, counter 0, RW registers INITIAL_VALUE, IRQ_STATUS 0, IRQ_ENABLE 0.
REQ-022 SHALL hold o_pready=0, o_prdata=0, o_pslverr=0, o_irq=0 during reset; reset mid-transfer drops it with no write.
REQ-023 SHALL ignore i_irq_set while rst=1.

Configuration
REQ-024 SHALL, with RGEN_APB_CSR_SLVERR_EN defined, assert o_pslverr with pready for unmapped accesses and for writes with pstrb=0.
REQ-025 SHALL, without RGEN_APB_CSR_SLVERR_EN, tie o_pslverr to 0; unmapped writes silently dropped.

Structure
REQ-026 SHALL place FSM state enum, rgen_access_type_e (RW, W1C) and address-index helpers in package rgen_csr_pkg.
REQ-027 SHALL implement the APB FSM and wait counter in sub-module rgen_apb_access_ctrl, outputting access_valid, access_write and word index.
REQ-028 SHALL keep register storage, W1C logic and read mux in rgen_apb_csr_bank itself.

Verification
REQ-029 SHALL test: reset, read word 0 with INITIAL_VALUE 32'hA5A5_0001 -> prdata 32'hA5A5_0001, pslverr 0.
REQ-030 SHALL test: write 32'h1234_5678 pstrb 4'b0011 to reg 1 (was 0) -> read 32'h0000_5678, o_rw_value slice 1 matches.
REQ-031 SHALL test: WAIT_STATES=3 -> pready exactly 4 cycles after penable rises.
REQ-032 SHALL test: i_irq_set=32'h4, enable=32'h4 -> o_irq 1 next cycle; W1C 32'h4 with same-cycle set -> status stays 32'h4.
REQ-033 SHALL test: read index NUM_RW+5 with SLVERR_EN -> prdata 0, pslverr 1; without -> pslverr 0.
REQ-034 SHALL test: psel drop mid-ACCESS of a write to reg 0 -> no pready, reg 0 unchanged.
